// File: rtl/frame_minmax_ctrl.sv
// frame_minmax_ctrl
//   Collects FRAME_LEN unsigned 4-bit samples over a valid/ready input
//   handshake and presents the frame maximum, minimum and an all-equal flag
//   over a valid/ready output handshake. The result is held stable until the
//   consumer takes it. No new frame is accepted while a result is held.
//
//   Optional feature: define FRAME_MINMAX_INDEX_EN to add out_max_idx and
//   out_min_idx. These give the 0-based frame positions of the first maximum
//   and the first minimum.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     sample offered
//   in_ready     block can accept a sample (decoded from state)
//   in_data[3:0] unsigned sample
//   out_valid    frame result available (only in HOLD)
//   out_ready    consumer accepts the result
//   out_max      largest sample of the frame
//   out_min      smallest sample of the frame
//   out_all_eq   all samples of the frame are equal
//   out_max_idx  (FRAME_MINMAX_INDEX_EN) position of first maximum
//   out_min_idx  (FRAME_MINMAX_INDEX_EN) position of first minimum
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | no sample of the current frame held
// ACCUM  | 1..FRAME_LEN-1 samples held, running values valid
// HOLD   | result presented, waiting for out_ready

module frame_minmax_ctrl #(
   parameter int FRAME_LEN = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_max,
   output logic [3:0] out_min,
   output logic       out_all_eq
`ifdef FRAME_MINMAX_INDEX_EN
   ,
   output logic [3:0] out_max_idx,
   output logic [3:0] out_min_idx
`endif
);

   localparam logic [3:0] LAST_CNT = 4'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] max_q, max_d;
   logic [3:0] min_q, min_d;
   logic       all_eq_q, all_eq_d;
   logic       gt_max, lt_min, eq_max;
`ifdef FRAME_MINMAX_INDEX_EN
   logic [3:0] max_idx_q, max_idx_d;
   logic [3:0] min_idx_q, min_idx_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         max_q     <= 4'd0;
         min_q     <= 4'd0;
         all_eq_q  <= 1'b0;
`ifdef FRAME_MINMAX_INDEX_EN
         max_idx_q <= 4'd0;
         min_idx_q <= 4'd0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         max_q     <= max_d;
         min_q     <= min_d;
         all_eq_q  <= all_eq_d;
`ifdef FRAME_MINMAX_INDEX_EN
         max_idx_q <= max_idx_d;
         min_idx_q <= min_idx_d;
`endif
      end
   end

   // Strict compares keep the first occurrence of an extreme when values tie.
   always_comb begin
      gt_max = (in_data > max_q);
      lt_min = (in_data < min_q);
      eq_max = (in_data == max_q);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      max_d     = max_q;
      min_d     = min_q;
      all_eq_d  = all_eq_q;
`ifdef FRAME_MINMAX_INDEX_EN
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               max_d     = in_data;
               min_d     = in_data;
               all_eq_d  = 1'b1;
               cnt_d     = 4'd1;
`ifdef FRAME_MINMAX_INDEX_EN
               max_idx_d = 4'd0;
               min_idx_d = 4'd0;
`endif
               state_d   = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               // cnt_q is the 0-based position of the incoming sample.
               if (gt_max) begin
                  max_d = in_data;
`ifdef FRAME_MINMAX_INDEX_EN
                  max_idx_d = cnt_q;
`endif
               end
               if (lt_min) begin
                  min_d = in_data;
`ifdef FRAME_MINMAX_INDEX_EN
                  min_idx_d = cnt_q;
`endif
               end
               if (!eq_max) all_eq_d = 1'b0;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == LAST_CNT) state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      in_ready    = (state_q != S_HOLD);
      out_valid   = (state_q == S_HOLD);
      out_max     = max_q;
      out_min     = min_q;
      out_all_eq  = all_eq_q;
`ifdef FRAME_MINMAX_INDEX_EN
      out_max_idx = max_idx_q;
      out_min_idx = min_idx_q;
`endif
   end

endmodule
